mem_line_server: RTL and testbench

- Memory-side responder for the 2-way L1 cache line-fill/write-back interface.
- Answers cache line reads (4×16-bit words) and accepts dirty-line write-backs over a level-based 4-phase ack handshake, with configurable access latency.
- Holds the backing word store internally; sits between the cache and the top-level memory model.

---
 rtl/mem_line_server_pkg.sv | 22 ++
 rtl/mem_line_store.sv | 33 +++
 rtl/mem_line_server.sv | 157 +++++++++++++++
 tb/tb_mem_line_server.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_line_server_pkg.sv
// Shared constants, FSM state encoding and helpers for the cache-side memory line server.
package mem_line_server_pkg;
  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_W     = WORD_SIZE * LINE_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BUSY,
    ST_RD_BUSY,
    ST_DONE
  } state_e;

  // Bit offset of word 'off' within a packed line; word 0 occupies the top slice.
  function automatic int unsigned word_lsb(input int unsigned off, input int unsigned ws);
    return (LINE_WORDS - 1 - off) * ws;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/mem_line_store.sv
// Backing word store: whole-line synchronous write at one index, combinational line read.
module mem_line_store #(
  parameter int unsigned LINE_ADDR_W = 6,
  parameter int unsigned WORD_SIZE   = 16
) (
  input  logic                                                clk,
  input  logic                                                we_i,
  input  logic [LINE_ADDR_W-1:0]                              waddr_i,
  input  logic [mem_line_server_pkg::LINE_WORDS*WORD_SIZE-1:0] wline_i,
  input  logic [LINE_ADDR_W-1:0]                              raddr_i,
  output logic [mem_line_server_pkg::LINE_WORDS*WORD_SIZE-1:0] rline_o
);
  import mem_line_server_pkg::LINE_WORDS;
  import mem_line_server_pkg::word_lsb;

  // Contents are intentionally not reset.
  logic [WORD_SIZE-1:0] mem_q [2**LINE_ADDR_W][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned w = 0; w < LINE_WORDS; w++) begin
        mem_q[waddr_i][w] <= wline_i[word_lsb(w, WORD_SIZE) +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    rline_o = '0;
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      rline_o[word_lsb(w, WORD_SIZE) +: WORD_SIZE] = mem_q[raddr_i][w];
    end
  end
endmodule

// File: rtl/mem_line_server.sv
// Memory-side responder for L1 line fills and write-backs over a level-based 4-phase ack handshake.
module mem_line_server #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned LINE_ADDR_W = 6,
  parameter int unsigned WORD_SIZE   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_mem_read,
  input  logic [WORD_SIZE-1:0]   req_mem_read_address,
  input  logic                   req_mem_write,
  input  logic [WORD_SIZE-1:0]   req_mem_write_address,
  input  logic [4*WORD_SIZE-1:0] mem_fetch_output,
  output logic [4*WORD_SIZE-1:0] mem_fetch_input,
  output logic                   read_ack,
  output logic                   write_ack,
  output logic [15:0]            read_count,
  output logic [15:0]            write_count
);
  import mem_line_server_pkg::state_e;
  import mem_line_server_pkg::ST_IDLE;
  import mem_line_server_pkg::ST_WR_BUSY;
  import mem_line_server_pkg::ST_RD_BUSY;
  import mem_line_server_pkg::ST_DONE;
  import mem_line_server_pkg::sat_inc;

  localparam int unsigned LW     = 4 * WORD_SIZE;
  localparam logic [15:0] LAT_M1 = 16'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [LINE_ADDR_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [LW-1:0]          wr_data_q, wr_data_d, fetch_q, fetch_d;
  logic                   rd_pend_q, rd_pend_d, svc_rd_q, svc_rd_d, svc_wr_q, svc_wr_d;
  logic                   rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic [15:0]            rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                   store_we;
  logic [LW-1:0]          store_line;

  mem_line_store #(
    .LINE_ADDR_W(LINE_ADDR_W),
    .WORD_SIZE  (WORD_SIZE)
  ) u_store (
    .clk    (clk),
    .we_i   (store_we),
    .waddr_i(wr_idx_q),
    .wline_i(wr_data_q),
    .raddr_i(rd_idx_q),
    .rline_o(store_line)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    wr_data_d = wr_data_q;
    fetch_d   = fetch_q;
    rd_pend_d = rd_pend_q;
    svc_rd_d  = svc_rd_q;
    svc_wr_d  = svc_wr_q;
    rd_ack_d  = rd_ack_q;
    wr_ack_d  = wr_ack_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    store_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        svc_rd_d = req_mem_read;
        svc_wr_d = req_mem_write;
        if (req_mem_read) begin
          rd_idx_d = req_mem_read_address[LINE_ADDR_W+1:2];
          rd_ack_d = 1'b0;
        end
        // Write wins a simultaneous request; the read is parked and replayed after commit.
        if (req_mem_write) begin
          wr_idx_d  = req_mem_write_address[LINE_ADDR_W+1:2];
          wr_data_d = mem_fetch_output;
          wr_ack_d  = 1'b0;
          rd_pend_d = req_mem_read;
          state_d   = ST_WR_BUSY;
        end else if (req_mem_read) begin
          rd_pend_d = 1'b0;
          state_d   = ST_RD_BUSY;
        end
      end
      ST_WR_BUSY: begin
        if (cnt_q == LAT_M1) begin
          store_we  = 1'b1;
          wr_ack_d  = 1'b1;
          wr_cnt_d  = sat_inc(wr_cnt_q);
          cnt_d     = '0;
          rd_pend_d = 1'b0;
          state_d   = rd_pend_q ? ST_RD_BUSY : ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RD_BUSY: begin
        if (cnt_q == LAT_M1) begin
          fetch_d  = store_line;
          rd_ack_d = 1'b1;
          rd_cnt_d = sat_inc(rd_cnt_q);
          cnt_d    = '0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        if (!(svc_rd_q && req_mem_read) && !(svc_wr_q && req_mem_write)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_data_q <= '0;
      fetch_q   <= '0;
      rd_pend_q <= 1'b0;
      svc_rd_q  <= 1'b0;
      svc_wr_q  <= 1'b0;
      rd_ack_q  <= 1'b1;
      wr_ack_q  <= 1'b1;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_data_q <= wr_data_d;
      fetch_q   <= fetch_d;
      rd_pend_q <= rd_pend_d;
      svc_rd_q  <= svc_rd_d;
      svc_wr_q  <= svc_wr_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign mem_fetch_input = fetch_q;
  assign read_ack        = rd_ack_q;
  assign write_ack       = wr_ack_q;
  assign read_count      = rd_cnt_q;
  assign write_count     = wr_cnt_q;
endmodule

// File: tb/tb_mem_line_server.sv
// Randomized bench for mem_line_server against a line-array reference model.
module tb_mem_line_server;
  localparam int LAT = 4;
  localparam int NL  = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_r = 1'b0, req_w = 1'b0;
  logic [15:0] ra = '0, wa = '0;
  logic [63:0] wdat = '0;
  logic [63:0] fetch;
  logic        read_ack, write_ack;
  logic [15:0] read_count, write_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mem_m [NL];
  logic [63:0] fetch_m = '0;
  logic [15:0] rd_cnt_m = '0, wr_cnt_m = '0;

  mem_line_server #(
    .LATENCY    (LAT),
    .LINE_ADDR_W(6),
    .WORD_SIZE  (16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req_mem_read         (req_r),
    .req_mem_read_address (ra),
    .req_mem_write        (req_w),
    .req_mem_write_address(wa),
    .mem_fetch_output     (wdat),
    .mem_fetch_input      (fetch),
    .read_ack             (read_ack),
    .write_ack            (write_ack),
    .read_count           (read_count),
    .write_count          (write_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [15:0] addr);
    return (int'(addr) / 4) % NL;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ".fetch"}, fetch, fetch_m);
    check_eq({tag, ".rcnt"}, 64'(read_count), 64'(rd_cnt_m));
    check_eq({tag, ".wcnt"}, 64'(write_count), 64'(wr_cnt_m));
  endtask

  // One handshake: present requests, measure ack latency from the latching edge, then release.
  task automatic txn(input string tag, input bit dw, input bit dr, input logic [15:0] wadr,
                     input logic [15:0] radr, input logic [63:0] wd, input int hold);
    int  wr_lat = -1;
    int  rd_lat = -1;
    bit  done = 1'b0;
    @(negedge clk);
    req_w = dw; req_r = dr; wa = wadr; ra = radr; wdat = wd;
    @(posedge clk);
    #1;
    if (dw) check_eq({tag, ".wack_low"}, 64'(write_ack), 64'd0);
    if (dr) check_eq({tag, ".rack_low"}, 64'(read_ack), 64'd0);
    wa = 16'($urandom); ra = 16'($urandom); wdat = {$urandom, $urandom};
    for (int c = 1; c <= 4 * LAT + 8 && !done; c++) begin
      @(posedge clk);
      #1;
      if (dw && wr_lat < 0 && write_ack) wr_lat = c;
      if (dr && rd_lat < 0 && read_ack) rd_lat = c;
      done = (!dw || wr_lat >= 0) && (!dr || rd_lat >= 0);
    end
    if (dw) begin
      mem_m[line_of(wadr)] = wd;
      wr_cnt_m = sat(wr_cnt_m);
      check_eq({tag, ".wlat"}, 64'(wr_lat), 64'(LAT));
    end
    if (dr) begin
      fetch_m  = mem_m[line_of(radr)];
      rd_cnt_m = sat(rd_cnt_m);
      check_eq({tag, ".rlat"}, 64'(rd_lat), 64'(dw ? 2 * LAT : LAT));
    end
    check_state(tag);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check_eq({tag, ".held_rack"}, 64'(read_ack), 64'(dr));
      check_state({tag, ".held"});
    end
    @(negedge clk);
    req_w = 1'b0; req_r = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [63:0] d;
    for (int i = 0; i < NL; i++) mem_m[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.rack", 64'(read_ack), 64'd1);
    check_eq("rst.wack", 64'(write_ack), 64'd1);
    check_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NL; i++) begin
      d = {$urandom, $urandom};
      txn("preload", 1'b1, 1'b0, 16'(i * 4), 16'h0, d, 0);
    end

    txn("pre5", 1'b1, 1'b0, 16'h0014, 16'h0, 64'h1111_2222_3333_4444, 0);
    @(negedge clk);
    req_w = 1'b1; wa = 16'h0014; wdat = 64'hAAAA_AAAA_AAAA_AAAA;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; req_w = 1'b0;
    #1;
    rd_cnt_m = '0; wr_cnt_m = '0; fetch_m = '0;
    check_eq("midrst.rack", 64'(read_ack), 64'd1);
    check_eq("midrst.wack", 64'(write_ack), 64'd1);
    check_state("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    txn("midrst_rd", 1'b0, 1'b1, 16'h0, 16'h0014, 64'h0, 0);
    check_eq("midrst.data", fetch, 64'h1111_2222_3333_4444);

    txn("pre3", 1'b1, 1'b0, 16'h000C, 16'h0, 64'h0123_4567_89AB_CDEF, 0);
    txn("rd3", 1'b0, 1'b1, 16'h0, 16'h000D, 64'h0, 10);
    check_eq("rd3.data", fetch, 64'h0123_4567_89AB_CDEF);
    txn("wr_rd", 1'b1, 1'b1, 16'h0020, 16'h0022, 64'hDEAD_BEEF_CAFE_F00D, 0);
    check_eq("wr_rd.data", fetch, 64'hDEAD_BEEF_CAFE_F00D);
    txn("wrap_wr", 1'b1, 1'b0, 16'h0400, 16'h0, 64'h5A5A_0F0F_C3C3_9669, 0);
    txn("wrap_rd", 1'b0, 1'b1, 16'h0, 16'h0000, 64'h0, 0);
    check_eq("wrap.data", fetch, 64'h5A5A_0F0F_C3C3_9669);

    for (int t = 0; t < 40; t++) begin
      bit dw, dr;
      dw = 1'($urandom_range(0, 1));
      dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
      txn("rand", dw, dr, 16'($urandom), 16'($urandom), {$urandom, $urandom}, 0);
    end

    @(negedge clk);
    force dut.rd_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.rd_cnt_q;
    rd_cnt_m = 16'hFFFE;
    txn("sat1", 1'b0, 1'b1, 16'h0, 16'($urandom), 64'h0, 0);
    txn("sat2", 1'b0, 1'b1, 16'h0, 16'($urandom), 64'h0, 0);
    check_eq("sat.rcnt", 64'(read_count), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
